// File: rtl/alu_seq.sv
// alu_seq: sequenced, handshaked front-end for the 8-bit 6502 datapath ALU.
//
// Requests arrive on a valid/ready channel and results leave on another.
// ADC/SBC run nibble-serially: LO adds the low nibble, HI adds the high
// nibble and forms the flags. Decimal correction stays local to each nibble.
// All other ops finish in the accept cycle and go straight to DONE.
//
// Optional feature macro: ALU_BCD_EN
//   defined   - decimal correction is applied whenever the captured bcd=1
//   undefined - bcd is ignored, ADC/SBC are always binary, and the
//               correction logic is not built. LO/HI still sequence.
//
// Handshake rules (both channels): a transfer happens on the rising edge
// where valid & ready are both high. req_ready is high only in IDLE.
// rsp_valid is high only in DONE. While rsp_valid is high, y and the flags
// are held registers and do not change. There is no accept in the same
// cycle as a release: req_ready rises on the release edge.
module alu_seq (
    input  logic       clk,
    input  logic       resetb,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    input  logic       c_in,
    input  logic       bcd,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] y,
    output logic       zero,
    output logic       negative,
    output logic       overflow,
    output logic       c_out,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADC  = 4'h0;
    localparam logic [3:0] OP_SBC  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_EOR  = 4'h4;
    localparam logic [3:0] OP_LSR  = 4'h5;
    localparam logic [3:0] OP_PASS = 4'h6;
    localparam logic [3:0] OP_ASL  = 4'h7;
    localparam logic [3:0] OP_ROL  = 4'h8;
    localparam logic [3:0] OP_ROR  = 4'h9;

    state_t state, state_nxt;

    // Captured operands. b_r holds the effective operand (~b for SBC).
    logic [7:0] a_r;
    logic [7:0] b_r;
    logic       c_r;
    logic       sub_r;

    // Low-nibble result carried from LO into HI.
    logic [3:0] s_r;
    logic       c4_r;

    // Registered result and flags.
    logic [7:0] y_r;
    logic       zero_r;
    logic       neg_r;
    logic       ov_r;
    logic       cout_r;

    logic       accept;
    logic       is_arith;

`ifdef ALU_BCD_EN
    logic       bcd_r;
`else
    // bcd has no effect in a binary-only build.
    logic       unused_bcd;
    assign unused_bcd = bcd;
`endif

    assign accept   = req_valid && (state == ST_IDLE);
    assign is_arith = (op == OP_ADC) || (op == OP_SBC);

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = is_arith ? ST_LO : ST_DONE;
                end
            end
            ST_LO: begin
                state_nxt = ST_HI;
            end
            ST_HI: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Single-cycle ops, computed straight from the request inputs.
    logic [7:0] sc_y;
    logic       sc_c;

    // Logic/shift result for the non-arithmetic ops; reserved ops act as PASS.
    always_comb begin
        sc_y = a;
        sc_c = c_in;
        case (op)
            OP_OR:   sc_y = a | b;
            OP_AND:  sc_y = a & b;
            OP_EOR:  sc_y = a ^ b;
            OP_LSR: begin
                sc_y = {1'b0, a[7:1]};
                sc_c = a[0];
            end
            OP_PASS: sc_y = a;
            OP_ASL: begin
                sc_y = {a[6:0], 1'b0};
                sc_c = a[7];
            end
            OP_ROL: begin
                sc_y = {a[6:0], c_in};
                sc_c = a[7];
            end
            OP_ROR: begin
                sc_y = {c_in, a[7:1]};
                sc_c = a[0];
            end
            default: begin
                sc_y = a;
                sc_c = c_in;
            end
        endcase
    end

    // Low-nibble adder with optional decimal correction.
    logic [4:0] lo_sum;
    logic [3:0] lo_s;
    logic       lo_c4;

    // Low nibble: binary sum, then decimal adjust when enabled.
    always_comb begin
        lo_sum = {1'b0, a_r[3:0]} + {1'b0, b_r[3:0]} + {4'b0000, c_r};
        lo_s   = lo_sum[3:0];
        lo_c4  = lo_sum[4];
`ifdef ALU_BCD_EN
        if (bcd_r) begin
            if (!sub_r) begin
                if (lo_sum > 5'd9) begin
                    lo_s  = lo_sum[3:0] + 4'd6;
                    lo_c4 = 1'b1;
                end
            end else if (!lo_sum[4]) begin
                lo_s = lo_sum[3:0] - 4'd6;
            end
        end
`endif
    end

    // High-nibble adder; overflow uses the uncorrected high nibble.
    logic [4:0] hi_sum;
    logic [3:0] hi_h;
    logic       hi_c;
    logic       hi_ov;
    logic [7:0] hi_y;

    // High nibble: binary sum, flags, then decimal adjust when enabled.
    always_comb begin
        hi_sum = {1'b0, a_r[7:4]} + {1'b0, b_r[7:4]} + {4'b0000, c4_r};
        hi_h   = hi_sum[3:0];
        hi_c   = hi_sum[4];
        hi_ov  = (a_r[7] ^ hi_sum[3]) & (b_r[7] ^ hi_sum[3]);
`ifdef ALU_BCD_EN
        if (bcd_r) begin
            if (!sub_r) begin
                if (hi_sum > 5'd9) begin
                    hi_h = hi_sum[3:0] + 4'd6;
                    hi_c = 1'b1;
                end
            end else if (!hi_sum[4]) begin
                hi_h = hi_sum[3:0] - 4'd6;
            end
        end
`endif
        hi_y = {hi_h, s_r};
    end

    // Operand capture, nibble pipeline and registered result/flags.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            a_r    <= 8'h00;
            b_r    <= 8'h00;
            c_r    <= 1'b0;
            sub_r  <= 1'b0;
            s_r    <= 4'h0;
            c4_r   <= 1'b0;
            y_r    <= 8'h00;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
            ov_r   <= 1'b0;
            cout_r <= 1'b0;
`ifdef ALU_BCD_EN
            bcd_r  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_r   <= a;
                b_r   <= (op == OP_SBC) ? ~b : b;
                c_r   <= c_in;
                sub_r <= (op == OP_SBC);
`ifdef ALU_BCD_EN
                bcd_r <= bcd;
`endif
                if (!is_arith) begin
                    y_r    <= sc_y;
                    zero_r <= (sc_y == 8'h00);
                    neg_r  <= sc_y[7];
                    ov_r   <= 1'b0;
                    cout_r <= sc_c;
                end
            end
            if (state == ST_LO) begin
                s_r  <= lo_s;
                c4_r <= lo_c4;
            end
            if (state == ST_HI) begin
                y_r    <= hi_y;
                zero_r <= (hi_y == 8'h00);
                neg_r  <= hi_y[7];
                ov_r   <= hi_ov;
                cout_r <= hi_c;
            end
        end
    end

    assign y         = y_r;
    assign zero      = zero_r;
    assign negative  = neg_r;
    assign overflow  = ov_r;
    assign c_out     = cout_r;
    assign state_dbg = state;

endmodule
